// File: rtl/p18240_clock_ctrl.sv
// p18240_clock_ctrl: board-level clock/reset conditioner for the p18240.
// Debounces the raw pushbuttons and generates the processor clock and
// active-low reset from the fast board clock. Supports single-step,
// free-run at a divided rate and a timed reset pulse.
// Optional feature: define P18240_BREAKPOINT_EN to add a PC breakpoint
// (pc, bp_addr, bp_valid) that halts free-run at the end of a high phase.
module p18240_clock_ctrl #(
    parameter int unsigned DB_CYCLES  = 500000,
    parameter int unsigned HALF       = 12500000,
    parameter int unsigned RST_CYCLES = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        key_step,
    input  logic        key_run,
    input  logic        key_rst,
`ifdef P18240_BREAKPOINT_EN
    input  logic [15:0] pc,
    input  logic [15:0] bp_addr,
    input  logic        bp_valid,
`endif
    output logic        cpu_clock,
    output logic        cpu_reset_L,
    output logic        running,
    output logic [15:0] step_count
);

    // key indices within the packed key vectors
    localparam int unsigned K_STEP = 0;
    localparam int unsigned K_RUN  = 1;
    localparam int unsigned K_RST  = 2;

    localparam int unsigned DBW  = $clog2(DB_CYCLES + 1);
    localparam int unsigned CMAX = (HALF > RST_CYCLES) ? HALF : RST_CYCLES;
    localparam int unsigned CW   = $clog2(CMAX + 1);

    localparam logic [DBW-1:0] DB_LAST   = DBW'(DB_CYCLES - 1);
    localparam logic [CW-1:0]  HALF_LAST = CW'(HALF - 1);
    localparam logic [CW-1:0]  RST_LAST  = CW'(RST_CYCLES - 1);

    typedef enum logic [2:0] {
        S_RST,
        S_STOP,
        S_STEP_LO,
        S_RUN_LO,
        S_RUN_HI
    } state_t;

    logic [2:0]     sync1;
    logic [2:0]     sync2;
    logic [2:0]     acc;
    logic [2:0]     press;
    logic [DBW-1:0] db_cnt [3];

    state_t         state;
    logic [CW-1:0]  cnt;
    logic           stop_pend;
    logic           bp_hit;

    // two-flop synchronisers for the asynchronous pushbuttons
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= '1;
            sync2 <= '1;
        end else begin
            sync1 <= {key_rst, key_run, key_step};
            sync2 <= sync1;
        end
    end

    // debouncers: accept a new level after DB_CYCLES consecutive differing
    // samples; emit a one-cycle press pulse on an accepted fall only
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc   <= '1;
            press <= '0;
            for (int unsigned i = 0; i < 3; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 0; i < 3; i++) begin
                press[i] <= 1'b0;
                if (sync2[i] == acc[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    acc[i]    <= sync2[i];
                    db_cnt[i] <= '0;
                    press[i]  <= ~sync2[i];
                end else begin
                    db_cnt[i] <= db_cnt[i] + DBW'(1);
                end
            end
        end
    end

`ifdef P18240_BREAKPOINT_EN
    // breakpoint match, only consulted at the end of a RUN_HI half-period
    always_comb begin
        bp_hit = bp_valid && (pc == bp_addr);
    end
`else
    // no breakpoint hardware in this build
    always_comb begin
        bp_hit = 1'b0;
    end
`endif

    // clock/reset sequencer; all outputs are registered here so cpu_clock
    // leaves a flop directly
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= S_RST;
            cnt         <= RST_LAST;
            cpu_clock   <= 1'b1;
            cpu_reset_L <= 1'b0;
            running     <= 1'b0;
            step_count  <= '0;
            stop_pend   <= 1'b0;
        end else if (press[K_RST] && (state != S_RST)) begin
            state       <= S_RST;
            cnt         <= RST_LAST;
            cpu_clock   <= 1'b1;
            cpu_reset_L <= 1'b0;
            running     <= 1'b0;
            step_count  <= '0;
            stop_pend   <= 1'b0;
        end else begin
            unique case (state)
                S_RST: begin
                    if (cnt == '0) begin
                        state       <= S_STOP;
                        cpu_reset_L <= 1'b1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_STOP: begin
                    if (press[K_RUN]) begin
                        state     <= S_RUN_LO;
                        cpu_clock <= 1'b0;
                        cnt       <= HALF_LAST;
                        running   <= 1'b1;
                        stop_pend <= 1'b0;
                    end else if (press[K_STEP]) begin
                        state     <= S_STEP_LO;
                        cpu_clock <= 1'b0;
                        cnt       <= HALF_LAST;
                    end
                end
                S_STEP_LO: begin
                    if (cnt == '0) begin
                        state      <= S_STOP;
                        cpu_clock  <= 1'b1;
                        step_count <= step_count + 16'd1;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_RUN_LO: begin
                    if (press[K_RUN]) begin
                        stop_pend <= 1'b1;
                    end
                    if (cnt == '0) begin
                        state      <= S_RUN_HI;
                        cpu_clock  <= 1'b1;
                        step_count <= step_count + 16'd1;
                        cnt        <= HALF_LAST;
                    end else begin
                        cnt <= cnt - CW'(1);
                    end
                end
                S_RUN_HI: begin
                    if (cnt == '0) begin
                        // a run press landing on the final high cycle still
                        // stops here rather than one full period later
                        if (stop_pend || press[K_RUN] || bp_hit) begin
                            state     <= S_STOP;
                            running   <= 1'b0;
                            stop_pend <= 1'b0;
                        end else begin
                            state     <= S_RUN_LO;
                            cpu_clock <= 1'b0;
                            cnt       <= HALF_LAST;
                        end
                    end else begin
                        cnt <= cnt - CW'(1);
                        if (press[K_RUN]) begin
                            stop_pend <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= S_RST;
                    cnt   <= RST_LAST;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_p18240_clock_ctrl.sv
// Self-checking bench for p18240_clock_ctrl with small timing parameters.
// Expected behaviour comes from arithmetic on key run lengths and clock
// phase positions; define P18240_BREAKPOINT_EN to include the breakpoint phase.
module tb_p18240_clock_ctrl;

    localparam int unsigned DB   = 4;
    localparam int unsigned HALF = 3;
    localparam int unsigned RSTC = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        key_step = 1'b1;
    logic        key_run = 1'b1;
    logic        key_rst = 1'b1;
    logic        cpu_clock;
    logic        cpu_reset_L;
    logic        running;
    logic [15:0] step_count;
`ifdef P18240_BREAKPOINT_EN
    logic [15:0] pc;
    logic [15:0] bp_addr = 16'h0000;
    logic        bp_valid = 1'b0;
    assign pc = step_count;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned nfalls = 0;
    int unsigned nlows = 0;
    logic        prev_clk = 1'b1;

    always #5 clock = ~clock;

    p18240_clock_ctrl #(
        .DB_CYCLES(DB),
        .HALF(HALF),
        .RST_CYCLES(RSTC)
    ) dut (
        .clock(clock),
        .reset(reset),
        .key_step(key_step),
        .key_run(key_run),
        .key_rst(key_rst),
`ifdef P18240_BREAKPOINT_EN
        .pc(pc),
        .bp_addr(bp_addr),
        .bp_valid(bp_valid),
`endif
        .cpu_clock(cpu_clock),
        .cpu_reset_L(cpu_reset_L),
        .running(running),
        .step_count(step_count)
    );

    // count cpu_clock falling edges and low cycles, sampled mid-cycle
    always @(negedge clock) begin
        if (!reset) begin
            if (prev_clk && !cpu_clock) nfalls++;
            if (!cpu_clock) nlows++;
        end
        prev_clk = cpu_clock;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // expected free-run outputs j edges after entering the first low phase
    function automatic logic run_clk(input int j);
        return ((j / HALF) % 2) == 1;
    endfunction
    function automatic int run_rises(input int j);
        return (j + HALF) / (2 * HALF);
    endfunction

    int exp_cnt, base, kp, ks, js, kend, kd, m, r, j, i, f0, l0, pr;
    logic acc_m;
    int lens[$];

    initial begin
        // ---- reset values
        repeat (2) @(negedge clock);
        chk("rst_clk", 32'(cpu_clock), 32'd1);
        chk("rst_rstL", 32'(cpu_reset_L), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        chk("rst_count", 32'(step_count), 32'd0);
        reset = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clock);
            chk("release_rstL", 32'(cpu_reset_L), 32'(k >= int'(RSTC)));
            chk("release_clk", 32'(cpu_clock), 32'd1);
        end
        chk("release_count", 32'(step_count), 32'd0);
        exp_cnt = 0;

        // ---- single step, key held 10 cycles
        f0 = int'(nfalls);
        l0 = int'(nlows);
        key_step = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            chk("step_clk", 32'(cpu_clock),
                32'(!(k >= int'(DB + 3) && k < int'(DB + 3 + HALF))));
            chk("step_count", 32'(step_count),
                32'((k >= int'(DB + 3 + HALF)) ? exp_cnt + 1 : exp_cnt));
            if (k == 10) key_step = 1'b1;
        end
        exp_cnt++;
        chk("step_falls", 32'(int'(nfalls) - f0), 32'd1);
        chk("step_lowlen", 32'(int'(nlows) - l0), 32'(HALF));

        // ---- bouncing press: low 2, high 1, low 10
        f0 = int'(nfalls);
        l0 = int'(nlows);
        key_step = 1'b0;
        repeat (2) @(negedge clock);
        key_step = 1'b1;
        @(negedge clock);
        key_step = 1'b0;
        repeat (10) @(negedge clock);
        key_step = 1'b1;
        repeat (20) @(negedge clock);
        exp_cnt++;
        chk("bounce_falls", 32'(int'(nfalls) - f0), 32'd1);
        chk("bounce_lowlen", 32'(int'(nlows) - l0), 32'(HALF));
        chk("bounce_count", 32'(step_count), 32'(exp_cnt));

        // ---- random bouncing key traces against a run-length model
        for (int t = 0; t < 4; t++) begin
            lens.delete();
            for (int q = 0; q < 8; q++) lens.push_back(int'($urandom_range(1, 8)));
            acc_m = 1'b1;
            pr = 0;
            foreach (lens[q]) begin
                if ((q % 2) != int'(acc_m) && lens[q] >= int'(DB)) begin
                    acc_m = logic'(q % 2);
                    if (acc_m == 1'b0) pr++;
                end
            end
            f0 = int'(nfalls);
            l0 = int'(nlows);
            foreach (lens[q]) begin
                key_step = logic'(q % 2);
                repeat (lens[q]) @(negedge clock);
            end
            key_step = 1'b1;
            repeat (20) @(negedge clock);
            exp_cnt += pr;
            chk("rand_falls", 32'(int'(nfalls) - f0), 32'(pr));
            chk("rand_lowlen", 32'(int'(nlows) - l0), 32'(pr * int'(HALF)));
            chk("rand_count", 32'(step_count), 32'(exp_cnt & 16'hFFFF));
        end

        // ---- free run with an ignored step press, then a run press to stop
        base = exp_cnt;
        kp = int'($urandom_range(20, 40));
        ks = int'($urandom_range(8, 14));
        js = ((kp + 2 * int'(HALF) - 1) / (2 * int'(HALF))) * (2 * int'(HALF));
        kend = 7 + js + 8;
        key_run = 1'b0;
        for (int k = 1; k <= kend; k++) begin
            @(negedge clock);
            j = k - 7;
            if (k < 7) begin
                chk("run_pre_clk", 32'(cpu_clock), 32'd1);
                chk("run_pre_running", 32'(running), 32'd0);
                chk("run_pre_count", 32'(step_count), 32'(base));
            end else if (j < js) begin
                chk("run_clk", 32'(cpu_clock), 32'(run_clk(j)));
                chk("run_running", 32'(running), 32'd1);
                chk("run_count", 32'(step_count), 32'(base + run_rises(j)));
            end else begin
                chk("stop_clk", 32'(cpu_clock), 32'd1);
                chk("stop_running", 32'(running), 32'd0);
                chk("stop_count", 32'(step_count), 32'(base + js / (2 * int'(HALF))));
            end
            if (k == 8) key_run = 1'b1;
            if (k == ks) key_step = 1'b0;
            if (k == ks + 8) key_step = 1'b1;
            if (k == kp) key_run = 1'b0;
            if (k == kp + 8) key_run = 1'b1;
        end
        repeat (10) @(negedge clock);
        exp_cnt = base + js / (2 * int'(HALF));

        // ---- run, then rst press in a low phase; step press during RST ignored
        base = exp_cnt;
        m = int'($urandom_range(1, 3));
        r = int'($urandom_range(0, HALF - 1));
        kd = 2 * int'(HALF) * m + 1 + r;
        key_run = 1'b0;
        for (int k = 1; k <= kd + 15; k++) begin
            @(negedge clock);
            j = k - 7;
            if (k < 7) begin
                chk("rrun_pre_clk", 32'(cpu_clock), 32'd1);
                chk("rrun_pre_rstL", 32'(cpu_reset_L), 32'd1);
            end else if (k < kd + 7) begin
                chk("rrun_clk", 32'(cpu_clock), 32'(run_clk(j)));
                chk("rrun_count", 32'(step_count), 32'((base + run_rises(j)) & 16'hFFFF));
            end else begin
                i = k - (kd + 7);
                chk("rrst_clk", 32'(cpu_clock), 32'd1);
                chk("rrst_rstL", 32'(cpu_reset_L), 32'(i >= int'(RSTC)));
                chk("rrst_count", 32'(step_count), 32'd0);
                chk("rrst_running", 32'(running), 32'd0);
            end
            if (k == 8) key_run = 1'b1;
            if (k == kd) key_rst = 1'b0;
            if (k == kd + 8) key_rst = 1'b1;
            if (k == kd + 2) key_step = 1'b0;
            if (k == kd + 10) key_step = 1'b1;
        end
        repeat (10) @(negedge clock);
        chk("rrst_settled_count", 32'(step_count), 32'd0);
        chk("rrst_settled_clk", 32'(cpu_clock), 32'd1);
        exp_cnt = 0;

        // ---- counter wrap: preload 0xFFFF in STOP, then single step
        force dut.step_count = 16'hFFFF;
        @(negedge clock);
        release dut.step_count;
        @(negedge clock);
        key_step = 1'b0;
        repeat (8) @(negedge clock);
        key_step = 1'b1;
        repeat (12) @(negedge clock);
        chk("wrap_count", 32'(step_count), 32'd0);
        chk("wrap_clk", 32'(cpu_clock), 32'd1);

`ifdef P18240_BREAKPOINT_EN
        // ---- breakpoint at pc == 4 while running
        bp_addr  = 16'h0004;
        bp_valid = 1'b1;
        key_run  = 1'b0;
        repeat (8) @(negedge clock);
        key_run = 1'b1;
        repeat (50) @(negedge clock);
        chk("bp_count", 32'(step_count), 32'd4);
        chk("bp_clk", 32'(cpu_clock), 32'd1);
        chk("bp_running", 32'(running), 32'd0);
        bp_valid = 1'b0;
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
